// File: rtl/clock_upper_digits_pkg.sv
// Shared constants for the upper clock digits: active-low segment patterns,
// count limits and the BCD digit type.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [2:0] SEC_T_MAX = 3'd5;
  localparam logic [6:0] MIN_MAX   = 7'd59;
  localparam logic [6:0] HOUR_MAX  = 7'd23;

  // Two-digit BCD to binary; wide enough that illegal digits still compare above the limits.
  function automatic logic [6:0] bcd_val(input logic [2:0] tens, input bcd_t units);
    return 7'(tens) * 7'd10 + 7'(units);
  endfunction

endpackage

// File: rtl/clock_upper_digits_if.sv
// Inputs and display outputs of the upper clock digits, bundled for the stage boundary.
interface clock_upper_digits_if;
  logic       carry_in;
  logic       inc_min;
  logic       inc_hour;
  logic [6:0] disp_sec_tens;
  logic [6:0] disp_min_units;
  logic [6:0] disp_min_tens;
  logic [6:0] disp_hour_units;
  logic [6:0] disp_hour_tens;
  logic       carry_day;

  modport master (
    output carry_in, inc_min, inc_hour,
    input  disp_sec_tens, disp_min_units, disp_min_tens,
    input  disp_hour_units, disp_hour_tens, carry_day
  );

  modport slave (
    input  carry_in, inc_min, inc_hour,
    output disp_sec_tens, disp_min_units, disp_min_tens,
    output disp_hour_units, disp_hour_tens, carry_day
  );
endinterface

// File: rtl/clock_upper_digits_seg7_decode.sv
// BCD digit to active-low {g,f,e,d,c,b,a}; non-decimal codes blank the digit.
module seg7_decode
  import clock_pkg::*;
(
  input  bcd_t       bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/clock_upper_digits.sv
// Tens-of-seconds, minutes and hours counters driven by the units-stage carry,
// with minute/hour set pulses, registered 7-segment outputs and end-of-day pulse.
module clock_upper_digits
  import clock_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  clock_upper_digits_if.slave  bus
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tick;
  logic                   inc_min_q, inc_hour_q;

  logic [2:0] sec_t_q, sec_t_d;
  bcd_t       min_u_q, min_u_d;
  logic [2:0] min_t_q, min_t_d;
  bcd_t       hr_u_q, hr_u_d;
  logic [1:0] hr_t_q, hr_t_d;
  logic       min_step, hr_step;
  logic       day_d, day_pend_q, carry_day_q;

  logic [6:0] seg_sec_t, seg_min_u, seg_min_t, seg_hr_u, seg_hr_t;
  logic [6:0] disp_sec_t_q, disp_min_u_q, disp_min_t_q, disp_hr_u_q, disp_hr_t_q;

  // Flops reset high so a carry level already high at reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '1;
      prev_q     <= 1'b1;
      inc_min_q  <= 1'b0;
      inc_hour_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus.carry_in};
      prev_q     <= sync_q[SYNC_STAGES-1];
      inc_min_q  <= bus.inc_min;
      inc_hour_q <= bus.inc_hour;
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    sec_t_d  = sec_t_q;
    min_u_d  = min_u_q;
    min_t_d  = min_t_q;
    hr_u_d   = hr_u_q;
    hr_t_d   = hr_t_q;
    min_step = 1'b0;
    hr_step  = 1'b0;
    day_d    = 1'b0;

    if (tick) begin
      if (sec_t_q >= SEC_T_MAX) begin
        sec_t_d  = '0;
        min_step = (sec_t_q == SEC_T_MAX);
      end else begin
        sec_t_d = sec_t_q + 3'd1;
      end
    end

    // A natural step and a set pulse in the same cycle still move minutes by one.
    if (min_step || inc_min_q) begin
      if (min_u_q > 4'd9 || bcd_val(min_t_q, min_u_q) > MIN_MAX) begin
        min_u_d = '0;
        min_t_d = '0;
      end else if (bcd_val(min_t_q, min_u_q) == MIN_MAX) begin
        min_u_d = '0;
        min_t_d = '0;
        hr_step = min_step;
      end else if (min_u_q == 4'd9) begin
        min_u_d = '0;
        min_t_d = min_t_q + 3'd1;
      end else begin
        min_u_d = min_u_q + 4'd1;
      end
    end

    if (hr_step || inc_hour_q) begin
      if (hr_u_q > 4'd9 || bcd_val({1'b0, hr_t_q}, hr_u_q) > HOUR_MAX) begin
        hr_u_d = '0;
        hr_t_d = '0;
      end else if (bcd_val({1'b0, hr_t_q}, hr_u_q) == HOUR_MAX) begin
        hr_u_d = '0;
        hr_t_d = '0;
        day_d  = hr_step;
      end else if (hr_u_q == 4'd9) begin
        hr_u_d = '0;
        hr_t_d = hr_t_q + 2'd1;
      end else begin
        hr_u_d = hr_u_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_t_q <= '0;
      min_u_q <= '0;
      min_t_q <= '0;
      hr_u_q  <= '0;
      hr_t_q  <= '0;
    end else begin
      sec_t_q <= sec_t_d;
      min_u_q <= min_u_d;
      min_t_q <= min_t_d;
      hr_u_q  <= hr_u_d;
      hr_t_q  <= hr_t_d;
    end
  end

  seg7_decode u_seg_sec_t (.bcd_i({1'b0, sec_t_q}),  .seg_o(seg_sec_t));
  seg7_decode u_seg_min_u (.bcd_i(min_u_q),          .seg_o(seg_min_u));
  seg7_decode u_seg_min_t (.bcd_i({1'b0, min_t_q}),  .seg_o(seg_min_t));
  seg7_decode u_seg_hr_u  (.bcd_i(hr_u_q),           .seg_o(seg_hr_u));
  seg7_decode u_seg_hr_t  (.bcd_i({2'b00, hr_t_q}),  .seg_o(seg_hr_t));

  // End-of-day is delayed one extra stage so it lines up with the display registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_sec_t_q <= SEG_0;
      disp_min_u_q <= SEG_0;
      disp_min_t_q <= SEG_0;
      disp_hr_u_q  <= SEG_0;
      disp_hr_t_q  <= SEG_0;
      day_pend_q   <= 1'b0;
      carry_day_q  <= 1'b0;
    end else begin
      disp_sec_t_q <= seg_sec_t;
      disp_min_u_q <= seg_min_u;
      disp_min_t_q <= seg_min_t;
      disp_hr_u_q  <= seg_hr_u;
      disp_hr_t_q  <= seg_hr_t;
      day_pend_q   <= day_d;
      carry_day_q  <= day_pend_q;
    end
  end

  assign bus.disp_sec_tens   = disp_sec_t_q;
  assign bus.disp_min_units  = disp_min_u_q;
  assign bus.disp_min_tens   = disp_min_t_q;
  assign bus.disp_hour_units = disp_hr_u_q;
  assign bus.disp_hour_tens  = disp_hr_t_q;
  assign bus.carry_day       = carry_day_q;

endmodule
